// File: rtl/result_dump_reader_pkg.sv
// result_dump_reader_pkg: dump FSM states and default widths matching ARMProcessor.
package result_dump_reader_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    typedef enum logic [2:0] {IDLE, ADDR, CAPT, SEND, CSUM, DONE} dump_state_t;
endpackage

// File: rtl/result_dump_reader_if.sv
// result_dump_reader_if: processor result port plus valid/ready dump stream and control.
interface result_dump_reader_if
    import result_dump_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic [ADDR_W-1:0] result_add;
    logic [DATA_W-1:0] resultado_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    modport master (
        input  start, resultado_out, out_ready,
        output result_add, out_valid, out_data, out_last, busy, done
    );
    modport slave (
        output start, resultado_out, out_ready,
        input  result_add, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/result_dump_reader.sv
// result_dump_reader: walks result_add over FIRST_REG..LAST_REG and streams each word out.
// Optional RESULT_DUMP_CHECKSUM_EN appends an XOR checksum word carrying out_last.
module result_dump_reader
    import result_dump_reader_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 15
) (
    input logic clk,
    input logic rst,
    result_dump_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);
`ifdef RESULT_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    logic [DATA_W-1:0] r_acc;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic              w_at_last;
    logic              w_hs;
    assign w_at_last      = r_ptr == LAST_A;
    assign w_hs           = r_valid && bus.out_ready;
    assign bus.result_add = r_ptr;
    assign bus.out_valid  = r_valid;
    assign bus.out_data   = r_data;
    assign bus.out_last   = r_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    // The pointer doubles as result_add; it is compared before incrementing so LAST_REG=2**ADDR_W-1 never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= FIRST_A;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef RESULT_DUMP_CHECKSUM_EN
            r_acc   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= ADDR;
                    r_ptr   <= FIRST_A;
                    r_busy  <= 1'b1;
`ifdef RESULT_DUMP_CHECKSUM_EN
                    r_acc   <= '0;
`endif
                end
                ADDR: r_state <= CAPT;
                CAPT: begin
                    r_data  <= bus.resultado_out;
                    r_valid <= 1'b1;
                    r_last  <= w_at_last && !CSUM_EN;
                    r_state <= SEND;
`ifdef RESULT_DUMP_CHECKSUM_EN
                    r_acc   <= r_acc ^ bus.resultado_out;
`endif
                end
                SEND: if (w_hs) begin
                    r_valid <= 1'b0;
                    if (r_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
`ifdef RESULT_DUMP_CHECKSUM_EN
                    else if (w_at_last) r_state <= CSUM;
`endif
                    else begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_state <= ADDR;
                    end
                end
`ifdef RESULT_DUMP_CHECKSUM_EN
                CSUM: begin
                    r_data  <= r_acc;
                    r_valid <= 1'b1;
                    r_last  <= 1'b1;
                    r_state <= SEND;
                end
`endif
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_dump_reader.sv
// tb_result_dump_reader: directed table-driven checks of the register dump stream.
module tb_result_dump_reader;
`ifdef RESULT_DUMP_CHECKSUM_EN
    localparam int NW = 17, NW2 = 3;
`else
    localparam int NW = 16, NW2 = 2;
`endif
    typedef struct {
        int          stall;
        logic [31:0] data;
        logic        last;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[17];
    vec_t tbl2[3];
    always #5 clk = ~clk;
    result_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    result_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();
    result_dump_reader #(.DATA_W(32), .ADDR_W(5), .FIRST_REG(0), .LAST_REG(15))
        dut (.clk(clk), .rst(rst), .bus(bus));
    result_dump_reader #(.DATA_W(32), .ADDR_W(5), .FIRST_REG(30), .LAST_REG(31))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    // Register file model: one cycle of read latency after result_add.
    always_ff @(posedge clk) begin
        bus.resultado_out  <= 32'h1000_0000 + 32'(bus.result_add);
        bus2.resultado_out <= 32'h1000_0000 + 32'(bus2.result_add);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic take(input int k, input int stall);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("w%0d_valid", k), 32'(bus.out_valid), 1);
        chk($sformatf("w%0d_data", k), bus.out_data, tbl[k].data);
        chk($sformatf("w%0d_last", k), 32'(bus.out_last), 32'(tbl[k].last));
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk($sformatf("w%0d_stall_valid", k), 32'(bus.out_valid), 1);
                chk($sformatf("w%0d_stall_data", k), bus.out_data, tbl[k].data);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk($sformatf("w%0d_valid_drop", k), 32'(bus.out_valid), 0);
    endtask
    task automatic run_dump(input int stall_idx, input int stall_n, input int pulse_at);
        int extra = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        for (int k = 0; k < NW; k++) begin
            if (k == pulse_at) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            take(k, (k == stall_idx) ? stall_n : 0);
        end
        chk("done_pulse", 32'(bus.done), 1);
        chk("busy_in_done", 32'(bus.busy), 1);
        @(negedge clk);
        chk("done_cleared", 32'(bus.done), 0);
        chk("busy_cleared", 32'(bus.busy), 0);
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid || bus.done) extra++;
        end
        chk("no_extra_activity", 32'(extra), 0);
    endtask
    initial begin
        logic [31:0] x = '0;
        int n = 0;
        int got = 0;
        int dones = 0;
        int extra = 0;
        for (int i = 0; i < 16; i++) begin
            tbl[i].stall = 0;
            tbl[i].data  = 32'h1000_0000 + 32'(i);
            tbl[i].last  = (i == NW - 1);
            x ^= tbl[i].data;
        end
        tbl[16].stall = 0;
        tbl[16].data  = x;
        tbl[16].last  = 1'b1;
        tbl2[0].stall = 0;
        tbl2[0].data  = 32'h1000_001E;
        tbl2[0].last  = (NW2 == 2) ? 1'b0 : 1'b0;
        tbl2[1].stall = 0;
        tbl2[1].data  = 32'h1000_001F;
        tbl2[1].last  = (NW2 == 2);
        tbl2[2].stall = 0;
        tbl2[2].data  = 32'h1000_001E ^ 32'h1000_001F;
        tbl2[2].last  = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        bus2.start = 1'b0;
        bus2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_result_add", 32'(bus.result_add), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst2_result_add", 32'(bus2.result_add), 30);
        rst = 1'b0;
        @(negedge clk);
        run_dump(2, 5, -1);
        run_dump(-1, 0, 5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) take(k, 0);
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        chk("w7_before_rst", bus.out_data, tbl[7].data);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_result_add", 32'(bus.result_add), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_data", bus.out_data, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid || bus.done || bus.busy) extra++;
        end
        chk("midrst_quiet", 32'(extra), 0);
        run_dump(-1, 0, -1);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus2.out_valid) begin
                if (got < NW2) begin
                    chk($sformatf("top_w%0d_data", got), bus2.out_data, tbl2[got].data);
                    chk($sformatf("top_w%0d_last", got), 32'(bus2.out_last), 32'(tbl2[got].last));
                end
                got++;
            end
            if (bus2.done) dones++;
        end
        chk("top_word_count", 32'(got), 32'(NW2));
        chk("top_done_count", 32'(dones), 1);
        chk("top_result_add_end", 32'(bus2.result_add), 31);
        chk("top_busy_end", 32'(bus2.busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end
endmodule
